// File: rtl/bp_nexus_mdo_serializer.sv
// Nexus MDO/MSEO trace serializer.
// Turns {mcode, src_id, addr} trace packets into a header beat plus LSB-first
// address beats. Leading zero address bytes are suppressed, and every
// SYNC_PERIOD-th message carries the full address under SYNC_MCODE so an
// off-chip decoder can resynchronise.
module bp_nexus_mdo_serializer #(
  parameter int         ADDR_W      = 32,
  parameter int         SYNC_PERIOD = 16,
  parameter logic [5:0] SYNC_MCODE  = 6'd11
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic [ADDR_W+7:0] pkt_i,
  input  logic              pkt_v_i,
  output logic              pkt_ready_o,
  output logic [7:0]        mdo_o,
  output logic [1:0]        mseo_o,
  output logic              mdo_v_o,
  input  logic              mdo_ready_i,
  output logic [15:0]       msg_count_o
);

  localparam int NB    = ADDR_W / 8;
  localparam int CNT_W = $clog2(NB + 1);
  localparam int SC_W  = (SYNC_PERIOD > 1) ? $clog2(SYNC_PERIOD) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HDR  = 2'd1,
    S_ADDR = 2'd2
  } state_t;

  // Registered state and outputs
  state_t            r_state;
  logic [CNT_W-1:0]  r_idx;
  logic [CNT_W-1:0]  r_nbytes;
  logic [SC_W-1:0]   r_sync_cnt;
  logic [7:0]        r_mdo;
  logic [1:0]        r_mseo;
  logic              r_mdo_v;
  logic              r_pkt_ready;
  logic [15:0]       r_msg_count;
  logic [ADDR_W-1:0] r_addr;

  // Next-state values
  state_t            w_state;
  logic [CNT_W-1:0]  w_idx;
  logic [CNT_W-1:0]  w_nbytes;
  logic [SC_W-1:0]   w_sync_cnt;
  logic [7:0]        w_mdo;
  logic [1:0]        w_mseo;
  logic              w_mdo_v;
  logic              w_pkt_ready;
  logic [15:0]       w_msg_count;
  logic              w_capture;

  // Packet fields
  logic [5:0]        w_pkt_mcode;
  logic [1:0]        w_pkt_src;
  logic [ADDR_W-1:0] w_pkt_addr;
  logic              w_sync;
  logic [CNT_W-1:0]  w_last_idx;

  assign w_pkt_mcode = pkt_i[ADDR_W+7:ADDR_W+2];
  assign w_pkt_src   = pkt_i[ADDR_W+1:ADDR_W];
  assign w_pkt_addr  = pkt_i[ADDR_W-1:0];
  assign w_sync      = (r_sync_cnt == '0);
  assign w_last_idx  = r_nbytes - 1'b1;

  // Number of address beats: highest nonzero byte + 1, never fewer than one
  function automatic logic [CNT_W-1:0] f_nbytes(input logic [ADDR_W-1:0] a);
    logic [CNT_W-1:0] n;
    n = CNT_W'(1);
    for (int i = 1; i < NB; i++) begin
      if (a[i*8 +: 8] != 8'h00) n = CNT_W'(i + 1);
    end
    return n;
  endfunction

  // Address byte at a given beat index, LSB first
  function automatic logic [7:0] f_byte(input logic [ADDR_W-1:0] a,
                                        input logic [CNT_W-1:0]  idx);
    logic [ADDR_W-1:0] s;
    s = a >> {idx, 3'b000};
    return s[7:0];
  endfunction

  // Next-state and next-output decode; every register holds unless a beat moves
  always_comb begin
    w_state     = r_state;
    w_idx       = r_idx;
    w_nbytes    = r_nbytes;
    w_sync_cnt  = r_sync_cnt;
    w_mdo       = r_mdo;
    w_mseo      = r_mseo;
    w_mdo_v     = r_mdo_v;
    w_pkt_ready = r_pkt_ready;
    w_msg_count = r_msg_count;
    w_capture   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (pkt_v_i) begin
          w_capture   = 1'b1;
          w_state     = S_HDR;
          w_nbytes    = w_sync ? CNT_W'(NB) : f_nbytes(w_pkt_addr);
          w_sync_cnt  = (r_sync_cnt == SC_W'(SYNC_PERIOD - 1)) ? '0 : r_sync_cnt + 1'b1;
          w_mdo       = {w_pkt_src, (w_sync ? SYNC_MCODE : w_pkt_mcode)};
          w_mseo      = 2'b00;
          w_mdo_v     = 1'b1;
          w_pkt_ready = 1'b0;
        end
      end
      S_HDR: begin
        if (mdo_ready_i) begin
          w_state = S_ADDR;
          w_idx   = '0;
          w_mdo   = f_byte(r_addr, {CNT_W{1'b0}});
          w_mseo  = (r_nbytes == CNT_W'(1)) ? 2'b11 : 2'b00;
        end
      end
      S_ADDR: begin
        if (mdo_ready_i) begin
          if (r_idx == w_last_idx) begin
            // Final beat just left: drop back to the Nexus idle encoding
            w_state     = S_IDLE;
            w_mdo       = 8'h00;
            w_mseo      = 2'b11;
            w_mdo_v     = 1'b0;
            w_pkt_ready = 1'b1;
            w_msg_count = r_msg_count + 16'd1;
          end else begin
            w_idx  = r_idx + 1'b1;
            w_mdo  = f_byte(r_addr, w_idx);
            w_mseo = (w_idx == w_last_idx) ? 2'b11 : 2'b00;
          end
        end
      end
      default: begin
        w_state     = S_IDLE;
        w_mdo       = 8'h00;
        w_mseo      = 2'b11;
        w_mdo_v     = 1'b0;
        w_pkt_ready = 1'b1;
      end
    endcase
  end

  // State and output registers; reset abandons any message in flight
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state     <= S_IDLE;
      r_idx       <= '0;
      r_nbytes    <= '0;
      r_sync_cnt  <= '0;
      r_mdo       <= 8'h00;
      r_mseo      <= 2'b11;
      r_mdo_v     <= 1'b0;
      r_pkt_ready <= 1'b1;
      r_msg_count <= 16'd0;
    end else begin
      r_state     <= w_state;
      r_idx       <= w_idx;
      r_nbytes    <= w_nbytes;
      r_sync_cnt  <= w_sync_cnt;
      r_mdo       <= w_mdo;
      r_mseo      <= w_mseo;
      r_mdo_v     <= w_mdo_v;
      r_pkt_ready <= w_pkt_ready;
      r_msg_count <= w_msg_count;
    end
  end

  // Address capture; only meaningful once a packet is accepted, so no reset
  always_ff @(posedge clk_i) begin
    if (w_capture) r_addr <= w_pkt_addr;
  end

  assign pkt_ready_o = r_pkt_ready;
  assign mdo_o       = r_mdo;
  assign mseo_o      = r_mseo;
  assign mdo_v_o     = r_mdo_v;
  assign msg_count_o = r_msg_count;

endmodule

// File: tb/tb_bp_nexus_mdo_serializer.sv
// Bench for bp_nexus_mdo_serializer: directed and random packets, each
// message checked beat-by-beat against a message-level reference model.
module tb_bp_nexus_mdo_serializer;

  localparam int P = 4;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic [39:0] pkt_i;
  logic        pkt_v_i;
  logic        pkt_ready_o;
  logic [7:0]  mdo_o;
  logic [1:0]  mseo_o;
  logic        mdo_v_o;
  logic        mdo_ready_i;
  logic [15:0] msg_count_o;

  int n_chk     = 0;
  int n_fail    = 0;
  int k_acc     = 0;
  int exp_count = 0;

  bp_nexus_mdo_serializer #(
    .ADDR_W     (32),
    .SYNC_PERIOD(P),
    .SYNC_MCODE (6'd11)
  ) dut (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .pkt_i      (pkt_i),
    .pkt_v_i    (pkt_v_i),
    .pkt_ready_o(pkt_ready_o),
    .mdo_o      (mdo_o),
    .mseo_o     (mseo_o),
    .mdo_v_o    (mdo_v_o),
    .mdo_ready_i(mdo_ready_i),
    .msg_count_o(msg_count_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Address beats a message needs, from the value's magnitude
  function automatic int ref_nbytes(input logic [31:0] a, input bit sync);
    if (sync) return 4;
    if (a >= 32'h0100_0000) return 4;
    if (a >= 32'h0001_0000) return 3;
    if (a >= 32'h0000_0100) return 2;
    return 1;
  endfunction

  function automatic logic pick_ready(input int mode, input int j, input int stall);
    if (mode == 0) return 1'b1;
    if (mode == 1) return ($urandom_range(0, 3) != 0);
    return !(j == 2 && stall < 3);
  endfunction

  task automatic check_idle(input string tag, input int cnt);
    chk({tag, "_v"},     32'(mdo_v_o),     32'd0);
    chk({tag, "_mdo"},   32'(mdo_o),       32'd0);
    chk({tag, "_mseo"},  32'(mseo_o),      32'd3);
    chk({tag, "_ready"}, 32'(pkt_ready_o), 32'd1);
    chk({tag, "_count"}, 32'(msg_count_o), 32'(cnt));
  endtask

  // mode: 0 always ready, 1 random ready, 2 stall 3 cycles on address beat 1
  // abort_beat: beat index at which reset is pulsed (-1 = none)
  task automatic run_msg(input logic [5:0] mc, input logic [1:0] src,
                         input logic [31:0] addr, input int mode, input int abort_beat);
    logic [9:0] exp_q[$];
    bit sync;
    int n, j, stall, cyc, guard;
    sync = ((k_acc % P) == 0);
    n    = ref_nbytes(addr, sync);
    exp_q.push_back({2'b00, src, (sync ? 6'd11 : mc)});
    for (int b = 0; b < n; b++)
      exp_q.push_back({((b == n - 1) ? 2'b11 : 2'b00), addr[8*b +: 8]});

    guard = 0;
    @(negedge clk_i);
    while (!pkt_ready_o && guard < 50) begin
      @(negedge clk_i);
      guard++;
    end
    chk("pkt_ready_before", 32'(pkt_ready_o), 32'd1);
    pkt_i   = {mc, src, addr};
    pkt_v_i = 1'b1;
    @(posedge clk_i);
    #1;
    pkt_v_i = 1'b0;
    pkt_i   = {$urandom, 8'hA5};
    k_acc++;
    j     = 0;
    stall = 0;
    cyc   = 0;
    mdo_ready_i = pick_ready(mode, j, stall);
    if (!mdo_ready_i && mode == 2) stall++;
    while (j < n + 1 && cyc < 200) begin
      @(negedge clk_i);
      cyc++;
      chk("busy_ready", 32'(pkt_ready_o), 32'd0);
      chk("beat_v",     32'(mdo_v_o),     32'd1);
      chk($sformatf("beat%0d", j), 32'({mseo_o, mdo_o}), 32'(exp_q[j]));
      if (j == abort_beat) begin
        #2 reset_i = 1'b1;
        #1 check_idle("async_rst", 0);
        @(posedge clk_i);
        #2 reset_i = 1'b0;
        k_acc     = 0;
        exp_count = 0;
        return;
      end
      if (mdo_ready_i) j++;
      @(posedge clk_i);
      #1;
      mdo_ready_i = pick_ready(mode, j, stall);
      if (!mdo_ready_i && mode == 2) stall++;
    end
    chk("msg_timeout", 32'(j), 32'(n + 1));
    exp_count = (exp_count + 1) % 65536;
    @(negedge clk_i);
    check_idle("after_msg", exp_count);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    reset_i     = 1'b0;
    pkt_i       = '0;
    pkt_v_i     = 1'b0;
    mdo_ready_i = 1'b0;
    // Asynchronous reset between clock edges
    #3 reset_i = 1'b1;
    #1 check_idle("reset", 0);
    @(posedge clk_i);
    @(posedge clk_i);
    #2 reset_i = 1'b0;
    check_idle("reset_hold", 0);

    // First message is a full-length sync
    run_msg(6'd3, 2'd0, 32'h8000_0104, 0, -1);
    // Leading zero bytes suppressed, including the all-zero address
    run_msg(6'd3, 2'd1, 32'h0000_0120, 0, -1);
    run_msg(6'd3, 2'd0, 32'h0000_0000, 0, -1);
    // Backpressure on address beat 1
    run_msg(6'd5, 2'd2, 32'h0034_5678, 2, -1);
    // Reset during address beat 2 of a sync message
    run_msg(6'd9, 2'd1, 32'h1234_5678, 0, 3);
    // Sync cadence with SYNC_PERIOD=4
    for (int i = 0; i < 5; i++) run_msg(6'd7, 2'd3, 32'h0000_0010, 0, -1);
    chk("count_after_5", 32'(msg_count_o), 32'd5);
    // Random packets with random backpressure
    for (int i = 0; i < 30; i++) begin
      a = $urandom >> (8 * $urandom_range(0, 4));
      run_msg(6'($urandom), 2'($urandom), a, 1, -1);
    end
    chk("count_final", 32'(msg_count_o), 32'd35);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
